// File: rtl/srisc_mem_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports. Data has priority, with a streak guard for fetch.
// Define SRISC_MEM_ARB_TIMEOUT_EN to bound the mem_ack wait. Otherwise err is tied to 0.
module srisc_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t     state;
  logic       grant_d;
  logic [3:0] d_streak;
  logic       streak_full;
  logic       pick_d;
  logic       timeout;

  assign streak_full = (d_streak == 4'(MAX_D_STREAK));
  assign pick_d      = d_req && !(if_req && streak_full);

`ifdef SRISC_MEM_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_cnt;

  assign timeout = (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) && !mem_ack;

  // Counter is held at zero outside MEM, so it is already clear on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wait_cnt <= '0;
    else if (state != MEM)  wait_cnt <= '0;
    else if (!mem_ack)      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  // MEM never times out in this build.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_d   <= 1'b0;
      d_streak  <= '0;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            grant_d <= pick_d;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            state   <= MEM;
            if (pick_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (!if_req)           d_streak <= '0;
              else if (!streak_full) d_streak <= d_streak + 1'b1;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              d_streak  <= '0;
            end
          end
        end
        MEM: begin
          if (mem_ack || timeout) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err     <= timeout;
            state   <= RESP;
            // Stores and timed-out accesses return zero.
            if (grant_d) begin
              d_ack   <= 1'b1;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srisc_mem_arbiter.sv
// Bench for srisc_mem_arbiter: directed scenarios plus random two-port traffic
// checked by a transaction-level model with a responding memory.
module tb_srisc_mem_arbiter;

  localparam int MAX_D = 4;
`ifdef SRISC_MEM_ARB_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Memory behaviour knobs, set by the stimulus and read by the model.
  int          fixed_wait = 0;
  int          spur_pct = 0;
  bit          use_fix = 1'b0;
  logic [31:0] rdata_fix = '0;

  srisc_mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(MAX_D), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level reference: predicts each grant's winner from the request
  // levels and streak count, answers as memory, and expects the ack one cycle later.
  logic [1:0]  ack_due = '0;
  bit          err_due = 1'b0;
  logic [31:0] exp_rdata = '0;
  bit          prev_req = 1'b0;
  int          streak = 0;
  bit          win_d = 1'b0;
  bit          e_we = 1'b0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  int          waits = 0;
  int          mem_cycles = 0;

  always @(negedge clk) begin
    if (rst) begin
      mem_ack  = 1'b0;
      ack_due  = '0;
      err_due  = 1'b0;
      prev_req = 1'b0;
      streak   = 0;
    end else begin
      check_eq("acks", {if_ack, d_ack}, ack_due);
      check_eq("err", err, err_due);
      if (ack_due[1]) check_eq("if_rdata", if_rdata, exp_rdata);
      if (ack_due[0]) check_eq("d_rdata", d_rdata, exp_rdata);
      if (ack_due != 2'b00) check_eq("mem_req_drop", mem_req, 1'b0);
      ack_due = '0;
      err_due = 1'b0;
      if (mem_req && !prev_req) begin
        check_eq("grant_pending", if_req | d_req, 1'b1);
        win_d   = d_req && !(if_req && streak == MAX_D);
        streak  = (win_d && if_req) ? ((streak < MAX_D) ? streak + 1 : MAX_D) : 0;
        e_we    = win_d && d_we;
        e_addr  = win_d ? d_addr : if_addr;
        e_wdata = d_wdata;
        waits   = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        mem_cycles = 0;
      end
      if (mem_req) begin
        mem_cycles++;
        check_eq("mem_we", mem_we, e_we);
        check_eq("mem_addr", mem_addr, e_addr);
        if (e_we) check_eq("mem_wdata", mem_wdata, e_wdata);
        if (waits == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = use_fix ? rdata_fix : $urandom;
          ack_due   = win_d ? 2'b01 : 2'b10;
          exp_rdata = e_we ? 32'h0 : mem_rdata;
        end else begin
          waits--;
          mem_ack = 1'b0;
          if (TO_CYC > 0 && mem_cycles == TO_CYC) begin
            ack_due   = win_d ? 2'b01 : 2'b10;
            exp_rdata = 32'h0;
            err_due   = 1'b1;
          end
        end
      end else begin
        mem_ack   = (int'($urandom_range(0, 99)) < spur_pct);
        mem_rdata = $urandom;
      end
      prev_req = mem_req;
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_any_ack(output logic [1:0] got);
    got = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        got = {if_ack, d_ack};
        break;
      end
    end
  endtask

  logic [1:0] order [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

  initial begin
    logic [1:0] got;
    int n;
    do_reset();
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_acks", {if_ack, d_ack}, 2'b00);

    // Reset in the middle of a data access.
    fixed_wait = 50;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    @(negedge clk); @(negedge clk);
    check_eq("t1_in_mem", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1 check_eq("t1_mem_req", mem_req, 1'b0);
    check_eq("t1_busy", busy, 1'b0);
    d_req = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t1_no_ack", d_ack, 1'b0);
      check_eq("t1_idle", busy, 1'b0);
    end

    // Zero-wait fetch.
    do_reset();
    fixed_wait = 0; use_fix = 1'b1; rdata_fix = 32'hA5A5_0001;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check_eq("t2_mem_req", mem_req, 1'b1);
    check_eq("t2_addr", mem_addr, 32'h10);
    check_eq("t2_we", mem_we, 1'b0);
    check_eq("t2_busy", busy, 1'b1);
    @(negedge clk);
    check_eq("t2_ack", if_ack, 1'b1);
    check_eq("t2_rdata", if_rdata, 32'hA5A5_0001);
    #1 if_req = 1'b0; use_fix = 1'b0;

    // Store with three wait cycles.
    fixed_wait = 3;
    @(negedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t3_req", mem_req, 1'b1);
      check_eq("t3_we", mem_we, 1'b1);
      check_eq("t3_addr", mem_addr, 32'h40);
      check_eq("t3_wdata", mem_wdata, 32'h1234_5678);
    end
    @(negedge clk);
    check_eq("t3_ack", d_ack, 1'b1);
    check_eq("t3_rdata", d_rdata, 32'h0);
    #1 d_req = 1'b0; d_we = 1'b0;

    // Contention with both ports held: D,D,D,D,I,D.
    do_reset();
    fixed_wait = -1;
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    for (int t = 0; t < 6; t++) begin
      wait_any_ack(got);
      check_eq("t4_order", got, order[t]);
      #1;
      if (got[1]) if_addr = if_addr + 32'd4;
      else        d_addr  = d_addr + 32'd4;
    end
    if_req = 1'b0; d_req = 1'b0;

    // mem_ack pulses outside MEM must be ignored.
    spur_pct = 100; fixed_wait = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t5_idle_busy", busy, 1'b0);
      check_eq("t5_idle_req", mem_req, 1'b0);
    end
    #1 if_req = 1'b1; if_addr = 32'h14;
    wait_any_ack(got);
    check_eq("t5_ack", got, 2'b10);
    #1 if_req = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) n++;
    end
    check_eq("t5_extra_acks", n, 0);
    check_eq("t5_busy", busy, 1'b0);
    spur_pct = 0;

`ifdef SRISC_MEM_ARB_TIMEOUT_EN
    // Fetch with no mem_ack at all.
    fixed_wait = 1000;
    @(negedge clk); #1 if_req = 1'b1; if_addr = 32'h20;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if_ack) break;
      if (mem_req) n++;
    end
    check_eq("t6_cycles", n, 16);
    check_eq("t6_ack", if_ack, 1'b1);
    check_eq("t6_err", err, 1'b1);
    check_eq("t6_rdata", if_rdata, 32'h0);
    #1 if_req = 1'b0;
    @(negedge clk);
    check_eq("t6_idle", busy, 1'b0);
`endif

    // Random traffic on both ports with random wait states and stray acks.
    do_reset();
    fixed_wait = -1; spur_pct = 25;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          int c;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          #1 if_addr = $urandom & 32'hFFFF_FFFC; if_req = 1'b1;
          c = 0;
          do begin @(negedge clk); c++; end while (!if_ack && c < 100);
          check_eq("rnd_if_done", if_ack, 1'b1);
          #1 if_req = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 60; k++) begin
          int c;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          #1 d_addr = $urandom & 32'hFFFF_FFFC; d_we = $urandom_range(0, 1) == 1;
          d_wdata = $urandom; d_req = 1'b1;
          c = 0;
          do begin @(negedge clk); c++; end while (!d_ack && c < 100);
          check_eq("rnd_d_done", d_ack, 1'b1);
          #1 d_req = 1'b0;
        end
      end
    join
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
